// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: requester/output channel bundle for rr_mux_arbiter.
// req_last exists only when RR_MUX_ARBITER_PACKET_LOCK_EN is defined.
interface rr_mux_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [IW-1:0]  out_idx;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    logic [N-1:0]   req_last;
    modport master (output req_valid, req_data, req_last, out_ready,
                    input  req_ready, out_valid, out_data, out_idx);
    modport slave  (input  req_valid, req_data, req_last, out_ready,
                    output req_ready, out_valid, out_data, out_idx);
`else
    modport master (output req_valid, req_data, out_ready,
                    input  req_ready, out_valid, out_data, out_idx);
    modport slave  (input  req_valid, req_data, out_ready,
                    output req_ready, out_valid, out_data, out_idx);
`endif
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin N:1 arbiter feeding one registered W-bit output slot.
// Optional packet lock via RR_MUX_ARBITER_PACKET_LOCK_EN.
module rr_mux_arbiter #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input logic            clk,
    input logic            rst,
    rr_mux_arbiter_if.slave bus
);
    logic [IW-1:0] last, g, idx, out_idx;
    logic [W-1:0]  out_data, sel;
    logic [N-1:0]  elig, ready;
    logic          out_valid, load, hit, xfer;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
    logic locked;
    // While locked, only the packet owner (held in last) may be granted.
    assign elig = locked ? bus.req_valid & (N'(1) << last) : bus.req_valid;
    always_ff @(posedge clk) begin
        if (rst)
            locked <= 1'b0;
        else if (xfer)
            locked <= ~bus.req_last[g];
    end
`else
    assign elig = bus.req_valid;
`endif
    assign load = ~out_valid | bus.out_ready;
    // Scan from farthest to nearest so the nearest eligible after last wins.
    always_comb begin
        g = '0;
        idx = '0;
        hit = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N);
            if (elig[idx]) begin
                g = idx;
                hit = 1'b1;
            end
        end
    end
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++)
            if (g == IW'(i))
                sel = bus.req_data[i*W +: W];
    end
    assign ready = (hit & load & ~rst) ? N'(1) << g : '0;
    assign xfer = |ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_idx <= '0;
            last <= IW'(N - 1);
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel;
                out_idx <= g;
                last <= g;
            end
        end
    end
    assign bus.req_ready = ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data = out_data;
    assign bus.out_idx = out_idx;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed stimulus with a scoreboard queue of accepted beats.
module tb_rr_mux_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    rr_mux_arbiter_if #(.N(N), .W(W)) bus ();
    rr_mux_arbiter #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    logic [9:0] sb [$];
    int m_last = 3;
    bit m_lock = 1'b0;
    logic [3:0] exp_rdy;
    int exp_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic cycle(input string tag);
        logic [3:0] v;
        @(negedge clk);
        v = bus.req_valid;
        if (m_lock) v = v & 4'(1 << m_last);
        exp_w = winner(v);
        exp_rdy = (!rst && exp_w >= 0 && (sb.size() == 0 || bus.out_ready)) ? 4'(1 << exp_w) : 4'b0;
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check({tag, ".out_idx"}, 32'(bus.out_idx), 32'(sb[0][9:8]));
            check({tag, ".out_data"}, 32'(bus.out_data), 32'(sb[0][7:0]));
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_last = 3;
            m_lock = 1'b0;
        end else begin
            if (sb.size() != 0 && bus.out_ready) void'(sb.pop_front());
            if (exp_rdy != 4'b0) begin
                sb.push_back({2'(exp_w), bus.req_data[exp_w*8 +: 8]});
                m_last = exp_w;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
                m_lock = !bus.req_last[exp_w];
`endif
            end
        end
        #1;
    endtask

    initial begin
        bus.req_valid = 4'hF;
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.out_ready = 1'b1;
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
        bus.req_last = 4'hF;
`endif
        @(posedge clk);
        #1;
        cycle("rst0");
        cycle("rst1");
        check("rst.out_data", 32'(bus.out_data), 32'h0);
        rst = 1'b0;
        cycle("first");
        check("first.idx", 32'(bus.out_idx), 32'd0);
        check("first.data", 32'(bus.out_data), 32'hA0);
        for (int i = 1; i <= 4; i++) begin
            cycle("rr");
            check("rr.idx", 32'(bus.out_idx), 32'(i % 4));
            check("rr.data", 32'(bus.out_data), 32'(8'hA0 + i % 4));
        end
        bus.out_ready = 1'b0;
        repeat (3) begin
            cycle("bp");
            check("bp.idx", 32'(bus.out_idx), 32'd0);
            check("bp.data", 32'(bus.out_data), 32'hA0);
        end
        bus.out_ready = 1'b1;
        cycle("release");
        check("release.idx", 32'(bus.out_idx), 32'd1);
        bus.req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle("skip");
            check("skip.valid", 32'(bus.out_valid), 32'd1);
            check("skip.idx", 32'(bus.out_idx), (i % 2 == 0) ? 32'd3 : 32'd1);
        end
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b0;
        cycle("pre_rst");
        rst = 1'b1;
        cycle("mid_rst");
        rst = 1'b0;
        check("mid_rst.valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        cycle("restart");
        check("restart.idx", 32'(bus.out_idx), 32'd0);
`ifdef RR_MUX_ARBITER_PACKET_LOCK_EN
        bus.req_valid = 4'b0100;
        bus.req_last = 4'b1011;
        cycle("lock0");
        check("lock0.idx", 32'(bus.out_idx), 32'd2);
        bus.req_valid = 4'b0001;
        cycle("lock_hold");
        check("lock_hold.valid", 32'(bus.out_valid), 32'd0);
        bus.req_valid = 4'b0101;
        cycle("lock1");
        check("lock1.idx", 32'(bus.out_idx), 32'd2);
        bus.req_last = 4'b1111;
        cycle("lock2");
        check("lock2.idx", 32'(bus.out_idx), 32'd2);
        cycle("unlock");
        check("unlock.idx", 32'(bus.out_idx), 32'd0);
`endif
        bus.req_valid = 4'b0;
        repeat (2) cycle("drain");
        check("drain.valid", 32'(bus.out_valid), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
